// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: channel FSM states and channel bit positions.
// Constants and helpers only; no latency and no backpressure apply.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } btn_state_t;

  // Bit position of each button inside the channel vectors.
  typedef enum int {
    CH_PAUSE     = 0,
    CH_CHOOSELVL = 1,
    CH_JUMP      = 2,
    CH_DUCK      = 3,
    CH_ADJ       = 4,
    CH_COUNT     = 5
  } btn_ch_t;

  localparam logic [4:0] DEF_RPT_MASK = 5'((1 << CH_JUMP) | (1 << CH_DUCK));
  localparam logic [4:0] DEF_TOG_MASK = 5'(1 << CH_PAUSE);

  // Bits needed to hold every value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: synchroniser, debounce FSM, hold/auto-repeat counter and toggle.
// Latency SYNC_STAGES + DB_CYCLES from a clean raw edge to level/press/rls; no backpressure.
module btn_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1_000_000,
  parameter int RPT_DELAY   = 50_000_000,
  parameter int RPT_PERIOD  = 10_000_000,
  parameter bit RPT_EN      = 1'b0,
  parameter bit TOG_EN      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic tog_clr,
  output logic level,
  output logic press,
  output logic rls,
  output logic rpt,
  output logic tog
);

  localparam int DBW = cnt_width(DB_CYCLES);
  localparam int HW  = cnt_width(RPT_DELAY);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  H_LAST   = HW'(RPT_DELAY - 1);
  localparam logic [HW-1:0]  H_MAX    = HW'(RPT_DELAY);
  localparam logic [HW-1:0]  H_RELOAD = HW'((RPT_PERIOD < RPT_DELAY) ? (RPT_DELAY - RPT_PERIOD) : 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;
  btn_state_t             state;
  logic [DBW-1:0]         db_cnt;
  logic [HW-1:0]          hold_cnt;
  logic                   hold_active;
  logic                   db_done;
  logic                   rel_accept;
  logic                   rpt_hit;

  assign sync_in     = sync_q[SYNC_STAGES-1];
  assign hold_active = (state == ST_HELD) || (state == ST_DB_RELEASE);
  assign db_done     = (db_cnt == DB_LAST);
  assign rel_accept  = hold_active && !sync_in && db_done;
  assign rpt_hit     = RPT_EN && hold_active && (hold_cnt == H_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // db_cnt is 0 in IDLE/HELD, so with DB_CYCLES == 1 a change is accepted on first sight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      db_cnt   <= '0;
      hold_cnt <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      rls      <= 1'b0;
      rpt      <= 1'b0;
      tog      <= 1'b0;
    end else begin
      press <= 1'b0;
      rls   <= 1'b0;
      rpt   <= rpt_hit && !rel_accept;
      if (TOG_EN && tog_clr) begin
        tog <= 1'b0;
      end

      if (rpt_hit) begin
        hold_cnt <= H_RELOAD;
      end else if (hold_active && (hold_cnt != H_MAX)) begin
        hold_cnt <= hold_cnt + HW'(1);
      end

      case (state)
        ST_IDLE, ST_DB_PRESS: begin
          if (!sync_in) begin
            state  <= ST_IDLE;
            db_cnt <= '0;
          end else if (db_done) begin
            state    <= ST_HELD;
            db_cnt   <= '0;
            hold_cnt <= '0;
            level    <= 1'b1;
            press    <= 1'b1;
            if (TOG_EN) begin
              tog <= tog_clr ? 1'b0 : ~tog;
            end
          end else begin
            state  <= ST_DB_PRESS;
            db_cnt <= db_cnt + DBW'(1);
          end
        end
        ST_HELD, ST_DB_RELEASE: begin
          if (sync_in) begin
            state  <= ST_HELD;
            db_cnt <= '0;
          end else if (db_done) begin
            state  <= ST_IDLE;
            db_cnt <= '0;
            level  <= 1'b0;
            rls    <= 1'b1;
          end else begin
            state  <= ST_DB_RELEASE;
            db_cnt <= db_cnt + DBW'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner_bank.sv
// Bank of N_CH independent button conditioners (debounce, press/release pulses, auto-repeat, toggle).
// Latency SYNC_STAGES + DB_CYCLES per channel; no backpressure, every event is a one-cycle pulse.
module btn_conditioner_bank
  import btn_pkg::*;
#(
  parameter int              N_CH        = int'(CH_COUNT),
  parameter int              SYNC_STAGES = 2,
  parameter int              DB_CYCLES   = 1_000_000,
  parameter int              RPT_DELAY   = 50_000_000,
  parameter int              RPT_PERIOD  = 10_000_000,
  parameter logic [N_CH-1:0] RPT_MASK    = DEF_RPT_MASK,
  parameter logic [N_CH-1:0] TOG_MASK    = DEF_TOG_MASK
) (
  input  logic            CLK,
  input  logic            RST_BTN,
  input  logic [N_CH-1:0] btn_raw,
  input  logic [N_CH-1:0] tog_clr,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rls,
  output logic [N_CH-1:0] rpt,
  output logic [N_CH-1:0] tog
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .RPT_DELAY   (RPT_DELAY),
      .RPT_PERIOD  (RPT_PERIOD),
      .RPT_EN      (RPT_MASK[g]),
      .TOG_EN      (TOG_MASK[g])
    ) u_ch (
      .clk     (CLK),
      .rst_n   (RST_BTN),
      .btn_raw (btn_raw[g]),
      .tog_clr (tog_clr[g]),
      .level   (level[g]),
      .press   (press[g]),
      .rls     (rls[g]),
      .rpt     (rpt[g]),
      .tog     (tog[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner_bank.sv
// Directed and random stimulus for btn_conditioner_bank, checked against a rule-level reference model.
module tb_btn_conditioner_bank;

  localparam int N  = 5;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 3;
  localparam logic [N-1:0] RMASK = 5'b01100;
  localparam logic [N-1:0] TMASK = 5'b00001;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] tog_clr = '0;
  logic [N-1:0] level, press, rls, rpt, tog;

  btn_conditioner_bank #(
    .N_CH(N), .SYNC_STAGES(SS), .DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP),
    .RPT_MASK(RMASK), .TOG_MASK(TOG_MASK_W())
  ) dut (
    .CLK(clk), .RST_BTN(rst_n), .btn_raw(btn_raw), .tog_clr(tog_clr),
    .level(level), .press(press), .rls(rls), .rpt(rpt), .tog(tog)
  );

  function automatic logic [N-1:0] TOG_MASK_W();
    return TMASK;
  endfunction

  always #5 clk = ~clk;

  // Reference model: a change is accepted once the input, seen SS edges late,
  // has disagreed with the accepted level for DB consecutive edges.
  logic [SS-1:0] past [N];
  int            run  [N];
  int            pcyc [N];
  logic [N-1:0]  m_acc = '0, m_press = '0, m_rls = '0, m_rpt = '0, m_tog = '0;
  int            cyc = 0;

  initial begin
    for (int i = 0; i < N; i++) begin
      past[i] = '0;
      run[i]  = 0;
      pcyc[i] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        past[i] <= '0;
        run[i]  <= 0;
        pcyc[i] <= 0;
      end
      m_acc <= '0; m_press <= '0; m_rls <= '0; m_rpt <= '0; m_tog <= '0;
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < N; i++) begin
        logic seen, a, np, nr, nrp, nt;
        int   r, age;
        seen = past[i][SS-1];
        a    = m_acc[i];
        r    = (seen != a) ? run[i] + 1 : 0;
        np = 1'b0; nr = 1'b0; nrp = 1'b0;
        if (r == DB) begin
          a = seen;
          r = 0;
          if (seen) np = 1'b1; else nr = 1'b1;
        end
        age = (cyc + 1) - pcyc[i];
        if (RMASK[i] && a && !np && age >= RD && ((age - RD) % RP) == 0) nrp = 1'b1;
        nt = m_tog[i];
        if (TMASK[i]) begin
          if (tog_clr[i]) nt = 1'b0;
          else if (np) nt = ~nt;
        end
        past[i]    <= {past[i][SS-2:0], btn_raw[i]};
        run[i]     <= r;
        if (np) pcyc[i] <= cyc + 1;
        m_acc[i]   <= a;
        m_press[i] <= np;
        m_rls[i]   <= nr;
        m_rpt[i]   <= nrp;
        m_tog[i]   <= nt;
      end
    end
  end

  int total = 0, bad = 0;
  int press_cnt [N], rls_cnt [N], rpt_cnt [N], last_press [N], last_rls [N];
  logic [N-1:0] rpt_seen;
  int all_press_hit, all_rls_hit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0; rls_cnt[i] = 0; rpt_cnt[i] = 0; last_press[i] = -100; last_rls[i] = -100;
    end
    rpt_seen = '0; all_press_hit = 0; all_rls_hit = 0;
  endtask

  task automatic cmp_model();
    chk("level", level, m_acc);
    chk("press", press, m_press);
    chk("release", rls, m_rls);
    chk("rpt", rpt, m_rpt);
    chk("tog", tog, m_tog);
    for (int i = 0; i < N; i++) begin
      if (press[i] === 1'b1) begin press_cnt[i]++; last_press[i] = cyc; end
      if (rls[i] === 1'b1) begin rls_cnt[i]++; last_rls[i] = cyc; end
      if (rpt[i] === 1'b1) rpt_cnt[i]++;
    end
    rpt_seen = rpt_seen | rpt;
    if (press === 5'b11111) all_press_hit++;
    if (rls === 5'b11111) all_rls_hit++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_model();
    end
  endtask

  int t0, t1;

  initial begin
    clr_counts();
    repeat (3) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_press", press, 0);
    chk("rst_release", rls, 0);
    chk("rst_rpt", rpt, 0);
    chk("rst_tog", tog, 0);
    rst_n = 1'b1;
    step(3);

    // clean press on ch2 held 30 cycles
    clr_counts();
    btn_raw[2] = 1'b1; t0 = cyc;
    step(30);
    btn_raw[2] = 1'b0; t1 = cyc;
    step(12);
    chk("ch2_press_lat", last_press[2] - t0, 6);
    chk("ch2_press_cnt", press_cnt[2], 1);
    chk("ch2_rpt_cnt", rpt_cnt[2], 8);
    chk("ch2_rel_lat", last_rls[2] - t1, 6);

    // bounce on ch3
    clr_counts();
    btn_raw[3] = 1'b1; step(3);
    btn_raw[3] = 1'b0; step(1);
    btn_raw[3] = 1'b1; t0 = cyc;
    step(15);
    chk("ch3_press_cnt", press_cnt[3], 1);
    chk("ch3_press_lat", last_press[3] - t0, 6);
    btn_raw[3] = 1'b0;
    step(10);
    chk("ch3_rel_cnt", rls_cnt[3], 1);

    // toggle on ch0: three presses, then a fourth with clear
    clr_counts();
    for (int k = 0; k < 3; k++) begin
      btn_raw[0] = 1'b1; step(8);
      chk("ch0_tog_seq", tog[0], ((k % 2) == 0) ? 1 : 0);
      btn_raw[0] = 1'b0; step(8);
    end
    btn_raw[0] = 1'b1; step(5);
    tog_clr[0] = 1'b1; step(2);
    tog_clr[0] = 1'b0; step(2);
    chk("ch0_tog_clr_wins", tog[0], 0);
    chk("ch0_press_cnt", press_cnt[0], 4);
    btn_raw[0] = 1'b0; step(8);

    // all channels in the same cycle
    clr_counts();
    btn_raw = '1;
    step(20);
    chk("all_press_same_cycle", all_press_hit, 1);
    chk("no_rpt_ch014", rpt_seen & 5'b10011, 0);
    chk("rpt_ch23", rpt_seen & 5'b01100, 5'b01100);
    btn_raw = '0;
    step(10);
    chk("all_rel_same_cycle", all_rls_hit, 1);

    // reset 3 cycles into the ch2 hold
    clr_counts();
    btn_raw[2] = 1'b1;
    step(9);
    chk("pre_rst_level2", level[2], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_level", level, 0);
    chk("midrst_press", press, 0);
    chk("midrst_release", rls, 0);
    chk("midrst_rpt", rpt, 0);
    chk("midrst_tog", tog, 0);
    step(2);
    rst_n = 1'b1;
    clr_counts(); t0 = cyc;
    step(10);
    chk("post_rst_press_lat", last_press[2] - t0, 6);
    chk("post_rst_no_release", rls_cnt[2], 0);
    btn_raw[2] = 1'b0;
    step(10);

    // random segments: from heavy bounce to slow presses
    for (int seg = 0; seg < 4; seg++) begin
      int span;
      span = 2 + seg * 5;
      repeat (400) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(span - 1, 0) == 0) btn_raw[i] = ~btn_raw[i];
          tog_clr[i] = ($urandom_range(15, 0) == 0);
        end
        step(1);
      end
    end
    btn_raw = '0; tog_clr = '0;
    step(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
